// File: rtl/mhd_dev_accum.sv
// Error-statistics accumulator for the Hamming-distance miter: sum, max and error count over a run.
// Optional MHD_THRESH_CNT_EN adds a per-run threshold input and an over-threshold counter.
module mhd_dev_accum #(
    parameter int DIST_W = 8,
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum_dist,
    output logic              sum_sat,
    output logic [DIST_W-1:0] max_dist,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  sample_cnt
`ifdef MHD_THRESH_CNT_EN
    ,
    input  logic [DIST_W-1:0] thresh,
    output logic [CNT_W-1:0]  over_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              sat_q, sat_d;
    logic [DIST_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [SUM_W:0]    sum_ext;
    logic [CNT_W-1:0]  cnt_inc;
    logic              xfer;
`ifdef MHD_THRESH_CNT_EN
    logic [DIST_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]  over_q, over_d;
`endif

    assign xfer    = in_valid && (state_q == ST_RUN);
    assign cnt_inc = cnt_q + CNT_W'(1);
    // One spare carry bit exposes overflow of the saturating sum.
    assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(in_dist);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        max_d   = max_q;
        err_d   = err_q;
`ifdef MHD_THRESH_CNT_EN
        thr_d   = thr_q;
        over_d  = over_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d     = n_samples;
                    cnt_d   = '0;
                    sum_d   = '0;
                    sat_d   = 1'b0;
                    max_d   = '0;
                    err_d   = '0;
`ifdef MHD_THRESH_CNT_EN
                    thr_d   = thresh;
                    over_d  = '0;
`endif
                    state_d = (n_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (sum_ext[SUM_W]) begin
                        sum_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[SUM_W-1:0];
                    end
                    if (in_dist > max_q) max_d = in_dist;
                    if (in_dist != '0) err_d = err_q + CNT_W'(1);
`ifdef MHD_THRESH_CNT_EN
                    if (in_dist > thr_q) over_d = over_q + CNT_W'(1);
`endif
                    if (cnt_inc == n_q) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            max_q   <= '0;
            err_q   <= '0;
`ifdef MHD_THRESH_CNT_EN
            thr_q   <= '0;
            over_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            max_q   <= max_d;
            err_q   <= err_d;
`ifdef MHD_THRESH_CNT_EN
            thr_q   <= thr_d;
            over_q  <= over_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign sum_dist   = sum_q;
    assign sum_sat    = sat_q;
    assign max_dist   = max_q;
    assign err_cnt    = err_q;
    assign sample_cnt = cnt_q;
`ifdef MHD_THRESH_CNT_EN
    assign over_cnt   = over_q;
`endif

endmodule
